issp_engine: RTL

- Parametrised Cypress M8C ISSP serial engine; successor of the fixed 22-bit bottom-half programmer.
- Generic vector width, SCLK timing, exec clock counts and POR wait.
- Adds a clean cmd/done handshake and bounded SDATA waits.
- Sits between the bus register file and the ZIF pin drivers; the register file handles address decode and multi-byte vector/mask loading.

---
 rtl/issp_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/issp_engine.sv
// issp_engine: parametrised Cypress M8C ISSP serial engine (POR, power-off, vector shift, exec).
// Optional macro ISSP_TIMEOUT_EN bounds the SDATA-low waits and reports aborts on error.
module issp_engine #(
    parameter int VEC_WIDTH   = 22,
    parameter int HALF_CYC    = 6,
    parameter int POR_WAIT    = 36000,
    parameter int EXEC_CLOCKS = 40,
    parameter int ZERO_CLOCKS = 40,
    parameter int TIMEOUT_CYC = 2400000
) (
    input  logic                 osc,
    input  logic                 rst,
    input  logic [2:0]           cmd,
    input  logic                 cmd_valid,
    input  logic [VEC_WIDTH-1:0] vector,
    input  logic [VEC_WIDTH-1:0] input_mask,
    output logic [VEC_WIDTH-1:0] rx_vector,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [3:0]           state_dbg,
    input  logic                 sdata_in,
    output logic                 sdata_out,
    output logic                 sdata_oe,
    output logic                 sclk_out,
    output logic                 sclk_oe,
    output logic                 vdd_en
);

    localparam int DLY_MAX0 = (POR_WAIT > HALF_CYC) ? POR_WAIT : HALF_CYC;
    localparam int DLY_MAX  = (TIMEOUT_CYC > DLY_MAX0) ? TIMEOUT_CYC : DLY_MAX0;
    localparam int DLY_W    = $clog2(DLY_MAX + 1);
    localparam int BIT_W    = (VEC_WIDTH > 1) ? $clog2(VEC_WIDTH) : 1;
    localparam int PLS_MAX  = (EXEC_CLOCKS > ZERO_CLOCKS) ? EXEC_CLOCKS : ZERO_CLOCKS;
    localparam int PLS_W    = $clog2(PLS_MAX + 1);

    localparam logic [DLY_W-1:0] DLY_ZERO  = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ONE   = DLY_W'(1);
    localparam logic [DLY_W-1:0] HALF_LAST = DLY_W'(HALF_CYC - 1);
    localparam logic [DLY_W-1:0] POR_LAST  = DLY_W'(POR_WAIT - 1);
    localparam logic [PLS_W-1:0] PLS_ZERO  = {PLS_W{1'b0}};
    localparam logic [PLS_W-1:0] PLS_ONE   = PLS_W'(1);
    localparam logic [PLS_W-1:0] EXEC_LAST = PLS_W'(EXEC_CLOCKS - 1);
    localparam logic [PLS_W-1:0] ZERO_LAST = PLS_W'(ZERO_CLOCKS - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(VEC_WIDTH - 1);

    localparam logic [2:0] CMD_POR     = 3'd1;
    localparam logic [2:0] CMD_PWROFF  = 3'd2;
    localparam logic [2:0] CMD_SENDVEC = 3'd3;
    localparam logic [2:0] CMD_EXEC    = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_POR_WAIT     = 4'd1,
        ST_WAIT_LO      = 4'd2,
        ST_SHIFT_LO     = 4'd3,
        ST_SHIFT_HI     = 4'd4,
        ST_SHIFT_END    = 4'd5,
        ST_EXEC_PRE_LO  = 4'd6,
        ST_EXEC_PRE_HI  = 4'd7,
        ST_EXEC_POLL_LO = 4'd8,
        ST_EXEC_POLL_HI = 4'd9,
        ST_EXEC_ZERO_LO = 4'd10,
        ST_EXEC_ZERO_HI = 4'd11,
        ST_FINISH       = 4'd12
    } state_t;

    state_t               state_r, state_s;
    logic [DLY_W-1:0]     dly_r, dly_s;
    logic [BIT_W-1:0]     bit_r, bit_s;
    logic [PLS_W-1:0]     pls_r, pls_s;
    logic [VEC_WIDTH-1:0] vec_r, vec_s, mask_r, mask_s, rx_r, rx_s;
    logic busy_r, busy_s, done_r, done_s, error_r, error_s;
    logic sdo_r, sdo_s, sdoe_r, sdoe_s, sclk_r, sclk_s, sclkoe_r, sclkoe_s, vdd_r, vdd_s;
    logic fin_s, lo_s, half_s, tmo_hit_s;

`ifdef ISSP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_r;

    // Cycles spent in the current SDATA-low wait; zero on entry to any wait state.
    always_ff @(posedge osc) begin
        if (rst) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if ((state_r == ST_WAIT_LO) || (state_r == ST_EXEC_POLL_LO) ||
                     (state_r == ST_EXEC_POLL_HI)) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end else begin
            tmo_r <= {TMO_W{1'b0}};
        end
    end

    assign tmo_hit_s = (tmo_r == TMO_LAST);
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s  = state_r;
        dly_s    = dly_r + DLY_ONE;
        bit_s    = bit_r;
        pls_s    = pls_r;
        vec_s    = vec_r;
        mask_s   = mask_r;
        rx_s     = rx_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        error_s  = error_r;
        sdo_s    = sdo_r;
        sdoe_s   = sdoe_r;
        sclk_s   = sclk_r;
        sclkoe_s = sclkoe_r;
        vdd_s    = vdd_r;
        fin_s    = 1'b0;
        lo_s     = 1'b0;
        half_s   = (dly_r == HALF_LAST);
        case (state_r)
            ST_IDLE, ST_FINISH: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                dly_s   = DLY_ZERO;
                if (cmd_valid && !busy_r) begin
                    case (cmd)
                        CMD_POR: begin
                            state_s  = ST_POR_WAIT;
                            busy_s   = 1'b1;
                            error_s  = 1'b0;
                            vdd_s    = 1'b1;
                            sclkoe_s = 1'b0;
                            sclk_s   = 1'b0;
                            sdoe_s   = 1'b0;
                            vec_s    = vector;
                            mask_s   = {VEC_WIDTH{1'b0}};
                        end
                        CMD_PWROFF: begin
                            error_s  = 1'b0;
                            vdd_s    = 1'b0;
                            sclkoe_s = 1'b0;
                            fin_s    = 1'b1;
                        end
                        CMD_SENDVEC: begin
                            busy_s   = 1'b1;
                            error_s  = 1'b0;
                            vec_s    = vector;
                            mask_s   = input_mask;
                            sclkoe_s = 1'b1;
                            bit_s    = BIT_TOP;
                            lo_s     = 1'b1;
                        end
                        CMD_EXEC: begin
                            state_s  = ST_EXEC_PRE_LO;
                            busy_s   = 1'b1;
                            error_s  = 1'b0;
                            sclkoe_s = 1'b1;
                            sclk_s   = 1'b0;
                            sdoe_s   = 1'b0;
                            pls_s    = PLS_ZERO;
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_POR_WAIT: begin
                if (dly_r == POR_LAST) begin
                    state_s  = ST_WAIT_LO;
                    sclkoe_s = 1'b1;
                    sclk_s   = 1'b0;
                end else begin
                    state_s = ST_POR_WAIT;
                end
            end
            ST_WAIT_LO: begin
                if (!sdata_in) begin
                    bit_s = BIT_TOP;
                    lo_s  = 1'b1;
                end else if (tmo_hit_s) begin
                    error_s = 1'b1;
                    fin_s   = 1'b1;
                end else begin
                    state_s = ST_WAIT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (half_s) begin
                    state_s = ST_SHIFT_HI;
                    dly_s   = DLY_ZERO;
                    sclk_s  = 1'b1;
                end else begin
                    state_s = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (half_s) begin
                    if (mask_r[bit_r]) begin
                        rx_s[bit_r] = sdata_in;
                    end else begin
                        rx_s = rx_r;
                    end
                    if (bit_r == BIT_ZERO) begin
                        state_s = ST_SHIFT_END;
                        dly_s   = DLY_ZERO;
                        sclk_s  = 1'b0;
                    end else begin
                        bit_s = bit_r - BIT_ONE;
                        lo_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_END: begin
                if (half_s) begin
                    fin_s = 1'b1;
                end else begin
                    state_s = ST_SHIFT_END;
                end
            end
            ST_EXEC_PRE_LO, ST_EXEC_ZERO_LO: begin
                if (half_s) begin
                    state_s = (state_r == ST_EXEC_PRE_LO) ? ST_EXEC_PRE_HI : ST_EXEC_ZERO_HI;
                    dly_s   = DLY_ZERO;
                    sclk_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_EXEC_PRE_HI: begin
                if (half_s) begin
                    dly_s  = DLY_ZERO;
                    sclk_s = 1'b0;
                    if (pls_r == EXEC_LAST) begin
                        state_s = ST_EXEC_POLL_LO;
                        pls_s   = PLS_ZERO;
                    end else begin
                        state_s = ST_EXEC_PRE_LO;
                        pls_s   = pls_r + PLS_ONE;
                    end
                end else begin
                    state_s = ST_EXEC_PRE_HI;
                end
            end
            ST_EXEC_POLL_LO: begin
                if (tmo_hit_s) begin
                    error_s = 1'b1;
                    fin_s   = 1'b1;
                end else if (half_s) begin
                    state_s = ST_EXEC_POLL_HI;
                    dly_s   = DLY_ZERO;
                    sclk_s  = 1'b1;
                end else begin
                    state_s = ST_EXEC_POLL_LO;
                end
            end
            ST_EXEC_POLL_HI: begin
                if (tmo_hit_s) begin
                    error_s = 1'b1;
                    fin_s   = 1'b1;
                end else if (half_s) begin
                    dly_s  = DLY_ZERO;
                    sclk_s = 1'b0;
                    // Target pulled SDATA low: hold it low ourselves for the trailing pulses.
                    if (!sdata_in) begin
                        state_s = ST_EXEC_ZERO_LO;
                        sdoe_s  = 1'b1;
                        sdo_s   = 1'b0;
                        pls_s   = PLS_ZERO;
                    end else begin
                        state_s = ST_EXEC_POLL_LO;
                    end
                end else begin
                    state_s = ST_EXEC_POLL_HI;
                end
            end
            ST_EXEC_ZERO_HI: begin
                if (half_s) begin
                    dly_s  = DLY_ZERO;
                    sclk_s = 1'b0;
                    if (pls_r == ZERO_LAST) begin
                        fin_s = 1'b1;
                    end else begin
                        state_s = ST_EXEC_ZERO_LO;
                        pls_s   = pls_r + PLS_ONE;
                    end
                end else begin
                    state_s = ST_EXEC_ZERO_HI;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        if (fin_s) begin
            state_s = ST_FINISH;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            sdoe_s  = 1'b0;
            sdo_s   = 1'b0;
            sclk_s  = 1'b0;
        end else if (lo_s) begin
            state_s = ST_SHIFT_LO;
            dly_s   = DLY_ZERO;
            sclk_s  = 1'b0;
            sdoe_s  = ~mask_s[bit_s];
            sdo_s   = vec_s[bit_s];
        end else begin
            done_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge osc) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            dly_r    <= DLY_ZERO;
            bit_r    <= BIT_ZERO;
            pls_r    <= PLS_ZERO;
            vec_r    <= {VEC_WIDTH{1'b0}};
            mask_r   <= {VEC_WIDTH{1'b0}};
            rx_r     <= {VEC_WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            sdo_r    <= 1'b0;
            sdoe_r   <= 1'b0;
            sclk_r   <= 1'b0;
            sclkoe_r <= 1'b0;
            vdd_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            dly_r    <= dly_s;
            bit_r    <= bit_s;
            pls_r    <= pls_s;
            vec_r    <= vec_s;
            mask_r   <= mask_s;
            rx_r     <= rx_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            error_r  <= error_s;
            sdo_r    <= sdo_s;
            sdoe_r   <= sdoe_s;
            sclk_r   <= sclk_s;
            sclkoe_r <= sclkoe_s;
            vdd_r    <= vdd_s;
        end
    end

    assign rx_vector = rx_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;
    assign state_dbg = state_r;
    assign sdata_out = sdo_r;
    assign sdata_oe  = sdoe_r;
    assign sclk_out  = sclk_r;
    assign sclk_oe   = sclkoe_r;
    assign vdd_en    = vdd_r;

endmodule
